// File: rtl/axis_uart_pkg.sv
// axis_uart_pkg: shared types and timing helpers for the AXIS UART blocks
package axis_uart_pkg;
  typedef enum logic [1:0] {PAR_NONE = 2'd0, PAR_EVEN = 2'd1, PAR_ODD = 2'd2} parity_e;
  typedef enum logic {ST_IDLE = 1'b0, ST_SHIFT = 1'b1} tx_state_e;
  function automatic int calc_tics_per_bit(input longint freq, input longint baud);
    return int'((freq + baud / 2) / baud);
  endfunction
  function automatic int frame_bits(input int data_bits, input parity_e parity, input int stop_bits);
    return 1 + data_bits + (parity != PAR_NONE ? 1 : 0) + stop_bits;
  endfunction
endpackage

// File: rtl/axis_uart_fifo.sv
// axis_uart_fifo: single-clock first-word-fall-through FIFO with registered level
module axis_uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             aclk,
  input  logic             areset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("axis_uart_fifo: DEPTH must be a power of two >= 2");
  end
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign full    = level == (AW + 1)'(DEPTH);
  assign empty   = level == '0;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];
  always_ff @(posedge aclk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      wr_ptr <= do_push ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr <= do_pop ? rd_ptr + 1'b1 : rd_ptr;
      level  <= level + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
    end
  end
endmodule

// File: rtl/axis_uart_tx_frame.sv
// axis_uart_tx_frame: AXI-Stream to UART transmitter with configurable frame format
// and an input FIFO; frames leave back-to-back while bytes are queued.
module axis_uart_tx_frame
  import axis_uart_pkg::*;
#(
  parameter int ACLK_FREQUENCY = 200000000,
  parameter int BAUD_RATE      = 9600,
  parameter int BAUD_RATE_SIM  = 50000000,
  parameter int DATA_BITS      = 8,
  parameter int PARITY         = 0,
  parameter int STOP_BITS      = 1,
  parameter int FIFO_DEPTH     = 4,
  localparam int LW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                 aclk,
  input  logic                 areset,
  output logic                 uart_txd,
  input  logic                 txbyte_tvalid,
  output logic                 txbyte_tready,
  input  logic [DATA_BITS-1:0] txbyte_tdata,
  input  logic                 txbyte_tkeep,
  output logic                 tx_busy,
  output logic [LW-1:0]        fifo_level
);
`ifdef SYNTHESIS
  localparam bit SIM = 1'b0;
`else
  localparam bit SIM = 1'b1;
`endif
  localparam int USED_BAUD_RATE = SIM ? BAUD_RATE_SIM : BAUD_RATE;
  localparam int TPB = calc_tics_per_bit(ACLK_FREQUENCY, USED_BAUD_RATE);
  localparam parity_e PAR = parity_e'(PARITY[1:0]);
  localparam int FB = frame_bits(DATA_BITS, PAR, STOP_BITS);
  localparam int TW = $clog2(TPB);
  localparam int BW = $clog2(FB);
  if (TPB < 2 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
      STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_cfg
    $error("axis_uart_tx_frame: illegal parameter set");
  end
  tx_state_e state, nxt;
  logic [FB-1:0] sr, sr_nxt, frame;
  logic [TW-1:0] tic_cnt;
  logic [BW-1:0] bit_cnt;
  logic [DATA_BITS-1:0] fifo_dout;
  logic [LW-1:0] level_nxt;
  logic fifo_full, fifo_empty, push, load, shift, last;
  assign push      = txbyte_tvalid && txbyte_tready && txbyte_tkeep && (!fifo_full || load);
  assign last      = state == ST_SHIFT && tic_cnt == '0 && bit_cnt == '0;
  assign level_nxt = fifo_level + LW'(push) - LW'(load);
  axis_uart_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .aclk  (aclk),
    .areset(areset),
    .push  (push),
    .din   (txbyte_tdata),
    .pop   (load),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );
  // LSB-first frame image: start bit at bit 0, stop ones at the top
  if (PAR == PAR_NONE) begin : g_no_par
    assign frame = {{STOP_BITS{1'b1}}, fifo_dout, 1'b0};
  end else begin : g_par
    assign frame = {{STOP_BITS{1'b1}}, (^fifo_dout) ^ (PAR == PAR_ODD), fifo_dout, 1'b0};
  end
  always_ff @(posedge aclk) begin
    state <= areset ? ST_IDLE : nxt;
  end
  always_comb begin
    nxt = (state == ST_IDLE || last) ? (fifo_empty ? ST_IDLE : ST_SHIFT) : state;
  end
  always_comb begin
    shift  = state == ST_SHIFT && tic_cnt == '0;
    load   = !fifo_empty && (state == ST_IDLE || last);
    sr_nxt = load ? frame : (shift ? {1'b1, sr[FB-1:1]} : sr);
  end
  // txd follows the next shift-register LSB so the start bit appears one cycle after the pop
  always_ff @(posedge aclk) begin
    if (areset) begin
      sr            <= '1;
      uart_txd      <= 1'b1;
      tic_cnt       <= '0;
      bit_cnt       <= '0;
      tx_busy       <= 1'b0;
      txbyte_tready <= 1'b0;
    end else begin
      sr            <= sr_nxt;
      uart_txd      <= sr_nxt[0];
      tic_cnt       <= (load || shift) ? TW'(TPB - 1) : (state == ST_SHIFT ? tic_cnt - 1'b1 : tic_cnt);
      bit_cnt       <= load ? BW'(FB - 1) : (shift ? bit_cnt - 1'b1 : bit_cnt);
      tx_busy       <= nxt == ST_SHIFT || level_nxt != '0;
      txbyte_tready <= level_nxt != LW'(FIFO_DEPTH);
    end
  end
endmodule

// File: tb/tb_axis_uart_tx_frame.sv
// tb_axis_uart_tx_frame: three frame formats (8N1, 7E2, 7O2) checked every cycle
// against a frame-schedule model, plus directed literal checks.
module tb_axis_uart_tx_frame;
  localparam int ND = 3;
  localparam int TPB = 4;
  localparam int DEPTH = 4;
  typedef struct { logic [8:0] d; int h; int s; } frm_t;
  logic clk = 1'b0;
  logic areset = 1'b1;
  logic [ND-1:0] tv = '0;
  logic [ND-1:0] tk = '0;
  logic [8:0] td [ND];
  logic [ND-1:0] txd, trdy, busy;
  logic [2:0] lvl [ND];
  frm_t fq [ND][$];
  int last_end [ND];
  int acc_cnt [ND];
  logic [ND-1:0] hs = '0;
  logic rst_prev = 1'b1;
  int cyc = 0;
  int total = 0;
  int bad = 0;
  int m_lv;
  logic m_on, m_et;
  frm_t m_f;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  axis_uart_tx_frame #(.ACLK_FREQUENCY(100000000), .BAUD_RATE_SIM(25000000), .DATA_BITS(8),
    .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) u_8n1 (
    .aclk(clk), .areset(areset), .uart_txd(txd[0]), .txbyte_tvalid(tv[0]), .txbyte_tready(trdy[0]),
    .txbyte_tdata(td[0][7:0]), .txbyte_tkeep(tk[0]), .tx_busy(busy[0]), .fifo_level(lvl[0]));
  axis_uart_tx_frame #(.ACLK_FREQUENCY(100000000), .BAUD_RATE_SIM(25000000), .DATA_BITS(7),
    .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(DEPTH)) u_7e2 (
    .aclk(clk), .areset(areset), .uart_txd(txd[1]), .txbyte_tvalid(tv[1]), .txbyte_tready(trdy[1]),
    .txbyte_tdata(td[1][6:0]), .txbyte_tkeep(tk[1]), .tx_busy(busy[1]), .fifo_level(lvl[1]));
  axis_uart_tx_frame #(.ACLK_FREQUENCY(100000000), .BAUD_RATE_SIM(25000000), .DATA_BITS(7),
    .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(DEPTH)) u_7o2 (
    .aclk(clk), .areset(areset), .uart_txd(txd[2]), .txbyte_tvalid(tv[2]), .txbyte_tready(trdy[2]),
    .txbyte_tdata(td[2][6:0]), .txbyte_tkeep(tk[2]), .tx_busy(busy[2]), .fifo_level(lvl[2]));
  function automatic int db(input int k); return k == 0 ? 8 : 7; endfunction
  function automatic int pb(input int k); return k; endfunction
  function automatic int sb(input int k); return k == 0 ? 1 : 2; endfunction
  function automatic int flen(input int k);
    return (1 + db(k) + (pb(k) != 0 ? 1 : 0) + sb(k)) * TPB;
  endfunction
  // bit i of the frame carrying byte d on DUT k (0 = start bit)
  function automatic logic fbit(input int k, input logic [8:0] d, input int i);
    if (i == 0) return 1'b0;
    if (i <= db(k)) return d[i-1];
    if (pb(k) != 0 && i == db(k) + 1) return (^d) ^ (pb(k) == 2);
    return 1'b1;
  endfunction
  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut=%0d cyc=%0d got=%0h want=%0h", nm, k, cyc, act, exp);
    end
  endtask
  // A frame for a byte accepted on cycle h starts at h+2, or right after the previous frame.
  always @(negedge clk) begin
    if (cyc >= 1) begin
      for (int k = 0; k < ND; k++) begin
        while (fq[k].size() > 0 && cyc >= fq[k][0].s + flen(k)) void'(fq[k].pop_front());
        m_lv = 0;
        for (int i = 0; i < fq[k].size(); i++)
          if (fq[k][i].h < cyc && cyc < fq[k][i].s) m_lv++;
        m_on = fq[k].size() > 0 && fq[k][0].s <= cyc;
        m_et = m_on ? fbit(k, fq[k][0].d, (cyc - fq[k][0].s) / TPB) : 1'b1;
        chk("txd", k, 32'(txd[k]), 32'(m_et));
        chk("level", k, 32'(lvl[k]), 32'(m_lv));
        chk("busy", k, 32'(busy[k]), 32'(m_lv > 0 || m_on));
        chk("tready", k, 32'(trdy[k]), 32'(!rst_prev && m_lv < DEPTH));
        hs[k] = !areset && tv[k] && trdy[k];
        if (hs[k]) acc_cnt[k]++;
        if (hs[k] && tk[k]) begin
          m_f.d = td[k] & ((9'd1 << db(k)) - 9'd1);
          m_f.h = cyc;
          m_f.s = (cyc + 2 > last_end[k]) ? cyc + 2 : last_end[k];
          last_end[k] = m_f.s + flen(k);
          fq[k].push_back(m_f);
        end
      end
      if (areset) for (int k = 0; k < ND; k++) begin
        fq[k].delete();
        last_end[k] = 0;
      end
      rst_prev = areset;
    end
  end
  task automatic send(input int k, input logic [8:0] d, input logic keep, output int hc);
    tv[k] = 1'b1;
    td[k] = d;
    tk[k] = keep;
    hc = -1;
    for (int n = 0; n < 400 && hc < 0; n++) begin
      @(negedge clk);
      if (trdy[k] && !areset) hc = cyc;
      @(posedge clk);
      #1;
    end
    if (hc < 0) begin
      total++;
      bad++;
      $display("FAIL send_timeout dut=%0d data=%0h", k, d);
    end
  endtask
  task automatic at(input int n);
    do @(negedge clk); while (cyc < n);
  endtask
  task automatic drain();
    int n = 0;
    while (busy != '0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 0, 32'(busy), 0);
    @(posedge clk);
    #1;
  endtask
  initial begin
    int h, h1, h2, h3, a0, n;
    for (int k = 0; k < ND; k++) begin
      td[k] = '0;
      last_end[k] = 0;
      acc_cnt[k] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    for (int k = 0; k < ND; k++) begin
      chk("rst_txd", k, 32'(txd[k]), 1);
      chk("rst_tready", k, 32'(trdy[k]), 0);
      chk("rst_level", k, 32'(lvl[k]), 0);
    end
    @(posedge clk);
    #1;
    areset = 1'b0;
    @(negedge clk);
    for (int k = 0; k < ND; k++) chk("tready_release", k, 32'(trdy[k]), 0);
    @(negedge clk);
    for (int k = 0; k < ND; k++) chk("tready_rise", k, 32'(trdy[k]), 1);
    @(posedge clk);
    #1;
    send(0, 9'h55, 1'b1, h);
    tv[0] = 1'b0;
    at(h + 2);  chk("x55_start", 0, 32'(txd[0]), 0);
    at(h + 6);  chk("x55_d0", 0, 32'(txd[0]), 1);
    at(h + 10); chk("x55_d1", 0, 32'(txd[0]), 0);
    at(h + 38); chk("x55_stop", 0, 32'(txd[0]), 1);
    at(h + 41); chk("x55_busy_hi", 0, 32'(busy[0]), 1);
    at(h + 42); chk("x55_busy_lo", 0, 32'(busy[0]), 0);
    @(posedge clk);
    #1;
    fork
      send(1, 9'h03, 1'b1, h1);
      send(2, 9'h03, 1'b1, h2);
    join
    tv[1] = 1'b0;
    tv[2] = 1'b0;
    at(h1 + 10); chk("x03_d1", 1, 32'(txd[1]), 1);
    at(h1 + 14); chk("x03_d2", 1, 32'(txd[1]), 0);
    at(h1 + 34); chk("x03_even_par", 1, 32'(txd[1]), 0);
    chk("x03_odd_par", 2, 32'(txd[2]), 1);
    at(h1 + 45); chk("x03_busy_hi", 1, 32'(busy[1]), 1);
    at(h1 + 46); chk("x03_busy_lo", 1, 32'(busy[1]), 0);
    drain();
    a0 = acc_cnt[0];
    fork
      begin
        for (int i = 0; i < 6; i++) send(0, 9'(9'hA0 + i), 1'b1, h);
        tv[0] = 1'b0;
      end
      begin
        n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (trdy[0] && n < 100);
        chk("burst_accepted", 0, 32'(acc_cnt[0] - a0), 5);
      end
    join
    drain();
    send(0, 9'h11, 1'b1, h1);
    send(0, 9'h00, 1'b0, h2);
    send(0, 9'h22, 1'b1, h3);
    tv[0] = 1'b0;
    chk("null_1cycle", 0, 32'(h2 - h1), 1);
    at(h1 + 41); chk("x11_stop", 0, 32'(txd[0]), 1);
    at(h1 + 42); chk("x22_start", 0, 32'(txd[0]), 0);
    drain();
    send(0, 9'h5A, 1'b1, h1);
    send(0, 9'hC3, 1'b1, h2);
    send(0, 9'h96, 1'b1, h3);
    tv[0] = 1'b0;
    at(h1 + 52);
    @(posedge clk);
    #1;
    areset = 1'b1;
    @(posedge clk);
    #1;
    areset = 1'b0;
    @(negedge clk);
    chk("midrst_txd", 0, 32'(txd[0]), 1);
    chk("midrst_level", 0, 32'(lvl[0]), 0);
    chk("midrst_busy", 0, 32'(busy[0]), 0);
    @(posedge clk);
    #1;
    send(0, 9'hE7, 1'b1, h);
    tv[0] = 1'b0;
    at(h + 2);  chk("after_rst_start", 0, 32'(txd[0]), 0);
    at(h + 6);  chk("after_rst_d0", 0, 32'(txd[0]), 1);
    drain();
    for (int t = 0; t < 4000; t++) begin
      @(posedge clk);
      #1;
      areset = $urandom_range(0, 999) == 0;
      for (int k = 0; k < ND; k++)
        if (!tv[k] || hs[k]) begin
          tv[k] = $urandom_range(0, 2) == 0;
          td[k] = 9'($urandom);
          tk[k] = $urandom_range(0, 7) != 0;
        end
    end
    @(posedge clk);
    #1;
    tv = '0;
    areset = 1'b0;
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/axis_uart_tx_frame.md
Name: axis_uart_tx_frame

Overview:
Parametrised AXI-Stream-to-UART transmitter, successor to the fixed 8N1 transmitter in the AxisUart interface library.
- Adds compile-time data width, parity mode and stop-bit count.
- Adds an input FIFO so that several bytes can be queued.
- Sends frames back-to-back with no idle gap, and discards null beats (tkeep=0) instead of stalling on them.
- Sits between an AXIS byte source (e.g. a packetiser) and the uart_txd pin.

Parameters:
ACLK_FREQUENCY, 200000000, aclk frequency in Hz.
BAUD_RATE, 9600, synthesis baud rate.
BAUD_RATE_SIM, 50000000, baud rate used in simulation (selected by translate_off region).
DATA_BITS, 8, payload bits per frame, legal 5..9.
PARITY, 0, 0=none, 1=even, 2=odd.
STOP_BITS, 1, legal 1 or 2.
FIFO_DEPTH, 4, input FIFO entries, power of two, >=2.

Ports:
aclk  in  1  clock.
areset  in  1  reset.
uart_txd  out  1  serial output, idle high.
txbyte_tvalid  in  1  AXIS valid.
txbyte_tready  out  1  AXIS ready (FIFO not full).
txbyte_tdata  in  DATA_BITS  payload, LSB transmitted first.
txbyte_tkeep  in  1  0 = null beat, consumed and dropped.
tx_busy  out  1  high while a frame is on the line or the FIFO is non-empty.
fifo_level  out  $clog2(FIFO_DEPTH)+1  number of queued entries.

Behaviour:
- Clock and reset: one clock, aclk. areset is synchronous and active-high. All state is cleared on the aclk edge where areset=1.
- Reset values: uart_txd=1, txbyte_tready=0, tx_busy=0, fifo_level=0, FIFO pointers=0, FSM=IDLE.
- txbyte_tready rises on the first cycle after areset deasserts. It equals !full, registered.
- Reset mid-frame aborts the frame: uart_txd=1 on the next cycle, FIFO contents are lost.
- Bit timing:
  - USED_BAUD_RATE = BAUD_RATE in synthesis, BAUD_RATE_SIM in simulation.
  - TICS_PER_BIT = (ACLK_FREQUENCY + USED_BAUD_RATE/2) / USED_BAUD_RATE, i.e. rounded to nearest.
  - Elaboration error if TICS_PER_BIT < 2 or if DATA_BITS, PARITY or STOP_BITS is outside its legal range.
- Frame format: start(0), DATA_BITS data LSB-first, parity bit if PARITY!=0, then STOP_BITS ones.
  - FRAME_BITS = 1 + DATA_BITS + (PARITY!=0) + STOP_BITS.
  - Each bit is held exactly TICS_PER_BIT cycles.
  - Even parity: parity bit = XOR of data bits. Odd parity: its complement.
- FIFO write: on tvalid && tready && tkeep, push tdata. A beat with tkeep=0 completes the handshake but is not pushed. Simultaneous push and pop is allowed when full: pop frees a slot, but tready stays registered-low that cycle.
- FSM states:
  - IDLE: uart_txd=1. If the FIFO is non-empty, pop, load the shift register {stop ones, parity, data, 0}, set tic_cnt=TICS_PER_BIT-1 and bit_cnt=FRAME_BITS-1, go to SHIFT.
  - SHIFT: decrement tic_cnt each cycle. When tic_cnt==0, shift right filling with 1 and reload tic_cnt. If bit_cnt==0, the frame is done:
    - FIFO non-empty: pop and reload in the same cycle, stay in SHIFT (zero idle gap).
    - FIFO empty: go to IDLE.
- uart_txd is the registered LSB of the shift register (glitch-free).
- Latency: with the FIFO empty and FSM in IDLE, handshake on cycle N → uart_txd=0 from cycle N+2.
- fifo_level and tx_busy are registered. tx_busy falls on the cycle the last stop bit ends with the FIFO empty.

Decomposition:
- Package axis_uart_pkg: parity_e enum (PAR_NONE, PAR_EVEN, PAR_ODD), function calc_tics_per_bit(freq, baud), function frame_bits(data_bits, parity, stop_bits). The future axis_uart_rx reuses all three.
- Sub-module axis_uart_fifo: synchronous single-clock FIFO, parametrised width and depth, with full/empty/level outputs.

Test Plan:
Run all scenarios with sim params ACLK_FREQUENCY=100000000, BAUD_RATE_SIM=25000000, so TICS_PER_BIT=4.
1. 8N1 reset check: after areset, uart_txd=1 and tready=0. Tready=1 one cycle after release.
2. 8N1, send 0x55: line shows 0,1,0,1,0,1,0,1,0,1, each 4 cycles, start at handshake+2; tx_busy falls 40 cycles after the start edge.
3. DATA_BITS=7, even parity, STOP_BITS=2, send 0x03 → start, 1100000, parity 0, stop 1, stop 1 (44 cycles). Odd parity → parity bit 1.
4. FIFO_DEPTH=4, burst 6 bytes 0xA0..0xA5:
   - tready drops after 4 queued plus 1 popped.
   - All 6 frames appear with no idle cycle between frames.
   - Byte order is preserved.
5. Beat with tkeep=0 between 0x11 and 0x22: only two frames appear; the handshake completes in 1 cycle.
6. Assert areset mid-data-bit of frame 2 of 3: uart_txd=1 and fifo_level=0 next cycle; a new byte afterwards transmits cleanly.
